// File: rtl/poly_mult_pkg.sv
// Shared definitions for the polynomial-multiplier scheduler: FSM encoding,
// default sizing and the stage-counter width helper.
package poly_mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int DEF_NREQ     = 2;
    localparam int DEF_N_STAGES = 4;

    // Stage counter must hold N_STAGES-1 and never collapse to zero bits.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first active request at or above the
// pointer (with wrap) wins; outputs are zero when disabled or nothing is requested.
module rr_arbiter
    import poly_mult_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    input  logic            en_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  gnt_id_o
);

    int              idx_s;
    int              sel_s;
    logic [NREQ-1:0] rot_s;

    // Scan from the farthest offset down so the nearest requester is written last.
    always_comb begin
        gnt_o    = '0;
        gnt_id_o = '0;
        idx_s    = 0;
        sel_s    = 0;
        rot_s    = '0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            idx_s = (int'(ptr_i) + off) % NREQ;
            rot_s = req_i >> idx_s;
            if (rot_s[0]) begin
                sel_s = idx_s;
            end else begin
                sel_s = sel_s;
            end
        end
        if (en_i && (|req_i)) begin
            gnt_o    = NREQ'(1'b1) << sel_s;
            gnt_id_o = IDW'(sel_s);
        end else begin
            gnt_o    = '0;
            gnt_id_o = '0;
        end
    end

endmodule

// File: rtl/poly_mult_scheduler.sv
// Grants the shared polynomial-multiplier datapath round-robin, clears the
// accumulator, walks one-hot stage enables and pulses done with the winner's ID.
module poly_mult_scheduler
    import poly_mult_pkg::*;
#(
    parameter int NREQ     = DEF_NREQ,
    parameter int N_STAGES = DEF_N_STAGES,
    parameter int IDW      = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic                abort,
    output logic                acc_clr,
    output logic [N_STAGES-1:0] stage_en,
    output logic [IDW-1:0]      op_sel,
    output logic                busy,
    output logic                done,
    output logic [IDW-1:0]      done_id
);

    localparam int             CW       = cnt_width(N_STAGES);
    localparam logic [CW-1:0]  LAST_CNT = CW'(N_STAGES - 1);
    localparam logic [IDW-1:0] LAST_ID  = IDW'(NREQ - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [IDW-1:0]  op_sel_q, op_sel_d;
    logic [IDW-1:0]  rr_q, rr_d;
    logic [NREQ-1:0] gnt_s;
    logic [IDW-1:0]  gnt_id_s;
    logic            arb_en_s;
    logic [IDW-1:0]  next_ptr_s;

    assign arb_en_s = (state_q == ST_IDLE);

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req_i    (req_valid),
        .ptr_i    (rr_q),
        .en_i     (arb_en_s),
        .gnt_o    (gnt_s),
        .gnt_id_o (gnt_id_s)
    );

    // Pointer moves just past the requester that last owned the datapath.
    always_comb begin
        if (op_sel_q == LAST_ID) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = op_sel_q + IDW'(1);
        end
    end

    // Next-state logic; abort only acts while the datapath is clearing or running.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        op_sel_d = op_sel_q;
        rr_d     = rr_q;
        case (state_q)
            ST_IDLE: begin
                if (|gnt_s) begin
                    op_sel_d = gnt_id_s;
                    state_d  = ST_CLEAR;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    rr_d    = next_ptr_s;
                end else begin
                    state_d = ST_RUN;
                    count_d = '0;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    rr_d    = next_ptr_s;
                end else if (count_q == LAST_CNT) begin
                    state_d = ST_DONE;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            ST_DONE: begin
                rr_d    = next_ptr_s;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from registered state only, except the grant handshake.
    always_comb begin
        req_ready = '0;
        acc_clr   = 1'b0;
        stage_en  = '0;
        busy      = 1'b0;
        done      = 1'b0;
        done_id   = '0;
        case (state_q)
            ST_IDLE: begin
                req_ready = gnt_s;
            end
            ST_CLEAR: begin
                acc_clr = 1'b1;
                busy    = 1'b1;
            end
            ST_RUN: begin
                stage_en = N_STAGES'(1'b1) << count_q;
                busy     = 1'b1;
            end
            ST_DONE: begin
                done    = 1'b1;
                done_id = op_sel_q;
                busy    = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign op_sel = op_sel_q;

    // State, stage counter, operand select and round-robin pointer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            op_sel_q <= '0;
            rr_q     <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            op_sel_q <= op_sel_d;
            rr_q     <= rr_d;
        end
    end

endmodule
